// File: rtl/block_feeder.sv
// Beatmap scanner: once per frame it streams in-window block descriptors to the
// renderer and permanently retires entries whose hit time has already passed.
module block_feeder #(
  parameter int unsigned NUM_BLOCKS  = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned WINDOW      = 4096,
  parameter int unsigned MAX_EMIT    = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [17:0]       curr_time,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [47:0]       mem_data_in,
  output logic [11:0]       block_x,
  output logic [11:0]       block_y,
  output logic [13:0]       block_z,
  output logic              block_color,
  output logic [2:0]        block_direction,
  output logic              block_visible,
  input  logic              block_ready_in,
  output logic              frame_done_out,
  output logic              busy_out,
  output logic [ADDR_W:0]   scan_base_out
);

  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_EMIT + 1);
  localparam int unsigned WCNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned ENT_W  = 46;
  localparam logic signed [18:0] WIN_S = 19'(WINDOW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    scan_base_q, scan_base_d;
  logic [CNT_W-1:0]    emit_cnt_q, emit_cnt_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [17:0]         t_q, t_d;
  logic [ENT_W-1:0]    entry_q, entry_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [11:0]         x_q, x_d;
  logic [11:0]         y_q, y_d;
  logic [13:0]         z_q, z_d;
  logic                color_q, color_d;
  logic [2:0]          dir_q, dir_d;
  logic                visible_q, visible_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [17:0]         hit_c;
  logic signed [18:0]  diff_c;
  logic [IDX_W-1:0]    idx_inc_c;
  logic                last_c;
  logic [CNT_W-1:0]    emit_inc_c;
  logic                unused_c;

  // Captured entry keeps bits [47:2]; the two spare bits carry nothing.
  assign unused_c   = ^mem_data_in[1:0];
  assign hit_c      = entry_q[45:28];
  assign diff_c     = $signed({1'b0, hit_c}) - $signed({1'b0, t_q});
  assign idx_inc_c  = idx_q + IDX_W'(1);
  assign last_c     = (idx_inc_c == IDX_W'(NUM_BLOCKS));
  assign emit_inc_c = emit_cnt_q + CNT_W'(1);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      scan_base_q <= '0;
      emit_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      t_q         <= '0;
      entry_q     <= '0;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      color_q     <= 1'b0;
      dir_q       <= '0;
      visible_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      scan_base_q <= scan_base_d;
      emit_cnt_q  <= emit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      t_q         <= t_d;
      entry_q     <= entry_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      color_q     <= color_d;
      dir_q       <= dir_d;
      visible_q   <= visible_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Scan sequencing: every entry goes READ -> WAIT -> CHECK, then EMIT or skip.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scan_base_d = scan_base_q;
    emit_cnt_d  = emit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    t_d         = t_q;
    entry_d     = entry_q;
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    color_d     = color_q;
    dir_d       = dir_q;
    visible_d   = visible_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          t_d        = curr_time;
          idx_d      = scan_base_q;
          emit_cnt_d = '0;
          if (scan_base_q == IDX_W'(NUM_BLOCKS)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            addr_d  = scan_base_q[ADDR_W-1:0];
          end
        end
      end
      S_READ: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WCNT_W'(MEM_LATENCY - 1)) begin
          entry_d = mem_data_in[47:2];
          state_d = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_CHECK: begin
        if (diff_c[18]) begin
          // Only a contiguous run of passed entries from the base is retired.
          if (idx_q == scan_base_q) begin
            scan_base_d = scan_base_q + IDX_W'(1);
          end
          idx_d = idx_inc_c;
          if (last_c) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            addr_d  = idx_inc_c[ADDR_W-1:0];
          end
        end else if (diff_c <= WIN_S) begin
          x_d       = entry_q[27:16];
          y_d       = entry_q[15:4];
          z_d       = diff_c[13:0];
          color_d   = entry_q[3];
          dir_d     = entry_q[2:0];
          visible_d = 1'b1;
          state_d   = S_EMIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_EMIT: begin
        if (visible_q && block_ready_in) begin
          visible_d  = 1'b0;
          emit_cnt_d = emit_inc_c;
          idx_d      = idx_inc_c;
          if ((emit_inc_c == CNT_W'(MAX_EMIT)) || last_c) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            addr_d  = idx_inc_c[ADDR_W-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign mem_addr_out    = addr_q;
  assign block_x         = x_q;
  assign block_y         = y_q;
  assign block_z         = z_q;
  assign block_color     = color_q;
  assign block_direction = dir_q;
  assign block_visible   = visible_q;
  assign frame_done_out  = done_q;
  assign busy_out        = busy_q;
  assign scan_base_out   = scan_base_q;

endmodule

// File: tb/tb_block_feeder.sv
// Bench for block_feeder: beatmap memory model plus a per-frame reference that
// lists the descriptors each scan should deliver and the resulting scan base.
module tb_block_feeder;

  localparam int NB = 64;
  localparam int W  = 4096;
  localparam int ME = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic [17:0] curr_time = '0;
  logic [5:0]  mem_addr_out;
  logic [47:0] mem_data_in;
  logic [11:0] block_x, block_y;
  logic [13:0] block_z;
  logic        block_color;
  logic [2:0]  block_direction;
  logic        block_visible;
  logic        block_ready_in = 1'b0;
  logic        frame_done_out, busy_out;
  logic [6:0]  scan_base_out;

  int checks = 0;
  int failures = 0;

  block_feeder dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .curr_time(curr_time), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .block_x(block_x), .block_y(block_y), .block_z(block_z),
    .block_color(block_color), .block_direction(block_direction),
    .block_visible(block_visible), .block_ready_in(block_ready_in),
    .frame_done_out(frame_done_out), .busy_out(busy_out),
    .scan_base_out(scan_base_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle read latency beatmap.
  logic [47:0] mem [NB];
  logic [47:0] pipe1;
  always @(posedge clk_in) begin
    pipe1       <= mem[mem_addr_out];
    mem_data_in <= pipe1;
  end

  // Reference model state and per-frame observations.
  int          model_sb;
  logic [41:0] exp_q[$];
  logic [41:0] obs_q[$];
  int          done_cnt, first_vis, first_acc, stab_err, vis_after, done_at;
  bit          timed_out, busy0;

  function automatic logic [41:0] cur_desc();
    return {block_x, block_y, block_z, block_color, block_direction};
  endfunction

  task automatic fill_sorted(input int unsigned start, input int unsigned max_step);
    int unsigned h;
    h = start;
    for (int i = 0; i < NB; i++) begin
      mem[i] = {18'(h), 12'($urandom), 12'($urandom), 1'($urandom),
                3'($urandom_range(4)), 2'($urandom)};
      h += $urandom_range(max_step);
    end
  endtask

  // Walk the sorted map from the base: passed entries are skipped (and retired
  // while still contiguous with the base), in-window ones are emitted up to ME.
  task automatic model_frame(input int t);
    bit live;
    int d;
    int start;
    exp_q.delete();
    live  = 1'b1;
    start = model_sb;
    for (int i = start; i < NB; i++) begin
      d = int'(mem[i][47:30]) - t;
      if (d < 0) begin
        if (live) model_sb++;
      end else begin
        live = 1'b0;
        if (d > W) break;
        exp_q.push_back({mem[i][29:18], mem[i][17:6], 14'(d), mem[i][5], mem[i][4:2]});
        if (exp_q.size() == ME) break;
      end
    end
  endtask

  // Run one frame; n counts negedges after the edge that sampled frame_start.
  task automatic run_frame(input int t, input int unsigned ready_pct,
                           input int hold, input bit poke_start);
    bit          held;
    bit          poked;
    logic [41:0] held_desc;
    int          hold_left;
    obs_q.delete();
    done_cnt = 0; first_vis = -1; first_acc = -1; stab_err = 0;
    vis_after = 0; done_at = -1; timed_out = 1'b0;
    held = 1'b0; poked = 1'b0; held_desc = '0; hold_left = 0;
    @(negedge clk_in);
    curr_time = 18'(t);
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    busy0 = busy_out;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) @(negedge clk_in);
      frame_start_in = 1'b0;
      curr_time = 18'($urandom);
      if (held && (!block_visible || cur_desc() !== held_desc)) stab_err++;
      if (done_at >= 0 && block_visible) vis_after++;
      if (block_visible && first_vis < 0) begin
        first_vis = n;
        hold_left = hold;
      end
      if (frame_done_out) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_at >= 0 && n >= done_at + 3) break;
      if (hold_left > 0) begin
        block_ready_in = 1'b0;
        hold_left--;
      end else begin
        block_ready_in = ($urandom_range(99) < ready_pct);
      end
      if (block_visible && block_ready_in) begin
        obs_q.push_back(cur_desc());
        if (first_acc < 0) first_acc = n;
      end
      if (poke_start && block_visible && !poked) begin
        frame_start_in = 1'b1;
        poked = 1'b1;
      end
      held = block_visible && !block_ready_in;
      held_desc = cur_desc();
    end
    if (done_at < 0) timed_out = 1'b1;
    frame_start_in = 1'b0;
    block_ready_in = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    frame_start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    model_sb = 0;
  endtask

  task automatic test_reset();
    fill_sorted(50000, 100);
    rst_in = 1'b0; block_ready_in = 1'b1; frame_start_in = 1'b0;
    repeat (4) @(negedge clk_in);
    checks++; if (mem_addr_out !== 6'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", mem_addr_out); end
    checks++; if (cur_desc() !== 42'd0) begin failures++; $display("FAIL reset_desc: got %h want 0", cur_desc()); end
    checks++; if (block_visible !== 1'b0) begin failures++; $display("FAIL reset_visible: got %b want 0", block_visible); end
    checks++; if (frame_done_out !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", frame_done_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    checks++; if (scan_base_out !== 7'd0) begin failures++; $display("FAIL reset_base: got %0d want 0", scan_base_out); end
    rst_in = 1'b1; model_sb = 0;
    model_frame(1000);
    run_frame(1000, 100, 0, 1'b0);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL reset_start_busy: got %b want 1", busy0); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reset_frame_emits: got %0d want 0", obs_q.size()); end
    checks++; if (done_cnt != 1 || timed_out) begin failures++; $display("FAIL reset_frame_done: got %0d pulses timeout=%0d want 1", done_cnt, timed_out); end
  endtask

  task automatic test_window_select();
    apply_reset();
    fill_sorted(6000, 50);
    mem[0][47:30] = 18'd100;
    mem[1][47:30] = 18'd500;
    mem[2][47:30] = 18'd5000;
    model_frame(200);
    run_frame(200, 100, 0, 1'b0);
    checks++; if (scan_base_out !== 7'd1) begin failures++; $display("FAIL win_base: got %0d want 1", scan_base_out); end
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL win_count: got %0d want 1", obs_q.size()); end
    checks++; if (obs_q.size() < 1 || obs_q[0][17:4] !== 14'd300) begin failures++; $display("FAIL win_z: got %0d want 300", (obs_q.size() > 0) ? obs_q[0][17:4] : 14'd0); end
    checks++; if (obs_q.size() < 1 || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL win_desc: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 42'd0, exp_q[0]); end
    checks++; if (done_cnt != 1 || timed_out) begin failures++; $display("FAIL win_done: got %0d pulses want 1", done_cnt); end
    checks++; if (first_vis != 8) begin failures++; $display("FAIL win_latency: got %0d want 8", first_vis); end
    checks++; if (vis_after != 0) begin failures++; $display("FAIL win_vis_after_done: got %0d want 0", vis_after); end
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset();
    fill_sorted(3000, 200);
    model_frame(3000);
    run_frame(3000, 100, 10, 1'b0);
    checks++; if (first_vis != 4) begin failures++; $display("FAIL bp_latency: got %0d want 4", first_vis); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
    checks++; if (first_acc - first_vis != 10) begin failures++; $display("FAIL bp_hold: got %0d cycles want 10", first_acc - first_vis); end
    checks++; if (obs_q.size() < 1 || obs_q[0][17:4] !== 14'd0) begin failures++; $display("FAIL bp_z_zero: got %0d want 0", (obs_q.size() > 0) ? obs_q[0][17:4] : 14'h3fff); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_desc: got %0d bad want 0", bad); end
  endtask

  task automatic test_limits();
    int bad;
    apply_reset();
    fill_sorted(20000, 100);
    for (int i = 0; i < 10; i++) mem[i][47:30] = 18'(10000 + i * 100);
    model_frame(10000);
    run_frame(10000, 70, 0, 1'b0);
    checks++; if (obs_q.size() != ME) begin failures++; $display("FAIL lim_max_emit: got %0d want %0d", obs_q.size(), ME); end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL lim_desc: got %0d bad want 0", bad); end
    checks++; if (done_cnt != 1 || timed_out) begin failures++; $display("FAIL lim_done: got %0d pulses want 1", done_cnt); end
    checks++; if (scan_base_out !== 7'd0) begin failures++; $display("FAIL lim_base: got %0d want 0", scan_base_out); end

    apply_reset();
    fill_sorted(30000, 100);
    mem[0][47:30] = 18'(10000 + W);
    mem[1][47:30] = 18'(10000 + W + 1);
    model_frame(10000);
    run_frame(10000, 100, 0, 1'b0);
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL lim_window_count: got %0d want 1", obs_q.size()); end
    checks++; if (obs_q.size() < 1 || obs_q[0][17:4] !== 14'd4096) begin failures++; $display("FAIL lim_window_z: got %0d want 4096", (obs_q.size() > 0) ? obs_q[0][17:4] : 14'd0); end
    checks++; if (obs_q.size() < 1 || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL lim_window_desc: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 42'd0, exp_q[0]); end
  endtask

  task automatic test_end_of_map();
    apply_reset();
    fill_sorted(0, 10);
    model_frame(100000);
    run_frame(100000, 100, 0, 1'b0);
    checks++; if (scan_base_out !== 7'd64) begin failures++; $display("FAIL eom_base: got %0d want 64", scan_base_out); end
    checks++; if (obs_q.size() != 0 || done_cnt != 1 || timed_out) begin failures++; $display("FAIL eom_frame: got %0d emits %0d pulses want 0 and 1", obs_q.size(), done_cnt); end
    run_frame(100500, 100, 0, 1'b0);
    checks++; if (done_at < 0 || done_at > 1) begin failures++; $display("FAIL eom_fast_done: got %0d want <=1", done_at); end
    checks++; if (first_vis != -1 || done_cnt != 1) begin failures++; $display("FAIL eom_no_visible: got vis_at=%0d pulses=%0d want -1 and 1", first_vis, done_cnt); end
  endtask

  task automatic test_random_frames();
    int t;
    int bad;
    apply_reset();
    fill_sorted(1000, 700);
    t = 0;
    for (int f = 0; f < 12; f++) begin
      t += $urandom_range(2500);
      model_frame(t);
      run_frame(t, $urandom_range(30, 100), 0, (f % 3) == 0);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0 || obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_desc: frame %0d got %0d emits (%0d bad) want %0d", f, obs_q.size(), bad, exp_q.size()); end
      checks++; if (scan_base_out !== 7'(model_sb)) begin failures++; $display("FAIL rand_base: frame %0d got %0d want %0d", f, scan_base_out, model_sb); end
      checks++; if (done_cnt != 1 || timed_out || stab_err != 0) begin failures++; $display("FAIL rand_done: frame %0d got %0d pulses, %0d unstable want 1 and 0", f, done_cnt, stab_err); end
    end
  endtask

  task automatic test_reset_mid_scan();
    apply_reset();
    fill_sorted(1000, 100);
    model_frame(1500);
    run_frame(1500, 100, 0, 1'b0);
    checks++; if (scan_base_out !== 7'(model_sb)) begin failures++; $display("FAIL mid_pre_base: got %0d want %0d", scan_base_out, model_sb); end
    @(negedge clk_in);
    curr_time = 18'd1500; frame_start_in = 1'b1; block_ready_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || block_visible !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: got busy=%b vis=%b want 0 0", busy_out, block_visible); end
    checks++; if (scan_base_out !== 7'd0) begin failures++; $display("FAIL mid_reset_base: got %0d want 0", scan_base_out); end
    checks++; if (frame_done_out !== 1'b0 || mem_addr_out !== 6'd0) begin failures++; $display("FAIL mid_reset_outs: got done=%b addr=%0d want 0 0", frame_done_out, mem_addr_out); end
    rst_in = 1'b1; model_sb = 0;
    block_ready_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_window_select();
    test_backpressure();
    test_limits();
    test_end_of_map();
    test_random_frames();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
